// File: rtl/scan_sequencer.sv
// Drives the select/enable pair of a 3-to-8 one-hot decoder, stepping through the
// masked-in lines with a programmable dwell; single-sweep or continuous operation.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic               en,
  output logic [2:0]         x,
  output logic               step,
  output logic               wrap,
  output logic               done,
  output logic               busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [2:0]         x_q, x_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [3:0]         first_in, first_sh, next_sh;
  logic [DWELL_W-1:0] reload_in, reload_sh;

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [3:0] find_up(input logic [7:0] m, input logic [3:0] lo);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(lo))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // A dwell of 0 holds each line for one cycle, same as a dwell of 1.
  function automatic logic [DWELL_W-1:0] reload_of(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  always_comb begin
    first_in  = find_up(mask, 4'd0);
    first_sh  = find_up(mask_q, 4'd0);
    next_sh   = find_up(mask_q, {1'b0, x_q} + 4'd1);
    reload_in = reload_of(dwell);
    reload_sh = reload_of(dwell_q);
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    x_d     = x_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop && (mask != 8'h00)) begin
          mode_d  = mode;
          dwell_d = dwell;
          mask_d  = mask;
          cnt_d   = reload_in;
          x_d     = first_in[2:0];
          state_d = ACTIVE;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          step_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (next_sh[3]) begin
          x_d    = next_sh[2:0];
          cnt_d  = reload_sh;
          step_d = 1'b1;
        end else if (!mode_q) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          x_d    = first_sh[2:0];
          cnt_d  = reload_sh;
          step_d = 1'b1;
          wrap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      x_q     <= 3'd0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      mask_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      x_q     <= x_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en   = en_q;
  assign x    = x_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: outputs are checked #1 after each rising edge
// against hand-derived {en, x, step, wrap, done, busy} vectors.
module tb_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic       en;
  logic [2:0] x;
  logic       step;
  logic       wrap;
  logic       done;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .dwell(dwell), .mask(mask), .en(en), .x(x), .step(step), .wrap(wrap),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic e, input logic [2:0] ex,
                     input logic s, input logic w, input logic d, input logic b);
    logic [7:0] obs, exp_v;
    obs   = {en, x, step, wrap, done, busy};
    exp_v = {e, ex, s, w, d, b};
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed{en,x,step,wrap,done,busy}=%b_%0d_%b%b%b%b expected=%b_%0d_%b%b%b%b",
             tag, obs[7], obs[6:4], obs[3], obs[2], obs[1], obs[0],
             exp_v[7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic launch(input logic m, input logic [7:0] dw, input logic [7:0] mk);
    mode  = m;
    dwell = dw;
    mask  = mk;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [2:0] sparse_lines [3];

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dwell = 8'd0; mask = 8'h00;
    #3;
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // Full single sweep, dwell 2
    launch(1'b0, 8'd2, 8'hFF);
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("sweep_ff_c%0d", c), 1, 3'(c / 2), (c % 2) == 0, 0, 0, 1);
      tick();
    end
    chk("sweep_ff_done", 0, 7, 0, 0, 1, 0);
    tick();
    chk("sweep_ff_after", 0, 7, 0, 0, 0, 0);

    // Sparse mask 1010_0100, dwell 3
    sparse_lines[0] = 3'd2; sparse_lines[1] = 3'd5; sparse_lines[2] = 3'd7;
    launch(1'b0, 8'd3, 8'b1010_0100);
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("sparse_c%0d", c), 1, sparse_lines[c / 3], (c % 3) == 0, 0, 0, 1);
      tick();
    end
    chk("sparse_done", 0, 7, 0, 0, 1, 0);
    tick();

    // Continuous 0,7,0,7 with stop
    launch(1'b1, 8'd1, 8'h81);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("cont81_c%0d", c), 1, (c % 2) ? 3'd7 : 3'd0, 1, (c > 0) && (c % 2 == 0), 0, 1);
      if (c == 4) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("cont81_stopped", 0, 0, 0, 0, 0, 0);
    tick();
    chk("cont81_still_idle", 0, 0, 0, 0, 0, 0);

    // dwell 0 behaves as 1
    launch(1'b0, 8'd0, 8'h06);
    chk("dwell0_c0", 1, 1, 1, 0, 0, 1);
    tick();
    chk("dwell0_c1", 1, 2, 1, 0, 0, 1);
    tick();
    chk("dwell0_done", 0, 2, 0, 0, 1, 0);
    tick();

    // start with empty mask is ignored
    launch(1'b0, 8'd1, 8'h00);
    chk("mask0_ignored", 0, 2, 0, 0, 0, 0);
    tick();
    chk("mask0_still_idle", 0, 2, 0, 0, 0, 0);

    // start with stop in IDLE is ignored
    stop = 1'b1;
    launch(1'b0, 8'd1, 8'hFF);
    stop = 1'b0;
    chk("start_stop_ignored", 0, 2, 0, 0, 0, 0);
    tick();
    chk("start_stop_still_idle", 0, 2, 0, 0, 0, 0);

    // start during ACTIVE with new settings is ignored
    launch(1'b0, 8'd2, 8'h03);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("restart_ign_c%0d", c), 1, 3'(c / 2), (c % 2) == 0, 0, 0, 1);
      if (c == 1) begin
        start = 1'b1; mask = 8'hF0; mode = 1'b1; dwell = 8'd5;
      end
      tick();
      start = 1'b0;
    end
    chk("restart_ign_done", 0, 1, 0, 0, 1, 0);
    tick();

    // Single line, continuous
    launch(1'b1, 8'd4, 8'h10);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("single_c%0d", c), 1, 4, (c % 4) == 0, (c > 0) && (c % 4 == 0), 0, 1);
      if (c == 11) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("single_stopped", 0, 4, 0, 0, 0, 0);
    tick();

    // Asynchronous reset mid-scan, then a normal scan
    launch(1'b0, 8'd5, 8'hFF);
    tick();
    tick();
    chk("pre_reset_active", 1, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_scan", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 0, 0, 0, 0, 0, 0);
    launch(1'b0, 8'd1, 8'h08);
    chk("post_reset_scan", 1, 3, 1, 0, 0, 1);
    tick();
    chk("post_reset_done", 0, 3, 0, 0, 1, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
